// File: rtl/phv_deparser_if.sv
// Slice/beat ingress and rebuilt-beat egress bundle of the PHV deparser.
// Handshake: i_phv_valid / i_pkt_valid are write strobes with no ready; a write into a full FIFO is dropped.
interface phv_deparser_if #(
  parameter int HEAD_WIDTH = 1024,
  parameter int TAG_WIDTH  = 8
);
  logic                            i_phv_valid;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv;
  logic                            i_pkt_valid;
  logic [133:0]                    i_pkt;
  logic                            o_pkt_valid;
  logic [133:0]                    o_pkt;

  modport slave (
    input  i_phv_valid, i_phv, i_pkt_valid, i_pkt,
    output o_pkt_valid, o_pkt
  );

  modport master (
    output i_phv_valid, i_phv, i_pkt_valid, i_pkt,
    input  o_pkt_valid, o_pkt
  );
endinterface

// File: rtl/phv_deparser.sv
// PHV deparser: rebuilds 134b beats from buffered original beats and processed PHV slices.
// Optional DEPARSER_CONF_DROP_EN: consume packets whose first beat has [31:16]==16'h9006 without emitting them.
module phv_deparser #(
  parameter int HEAD_WIDTH    = 1024,
  parameter int TAG_WIDTH     = 8,
  parameter int TAG_START_BIT = 0,
  parameter int TAG_TAIL_BIT  = 1,
  parameter int TAG_VALID_BIT = 3,
  parameter int PHV_DEPTH     = 16,
  parameter int PKT_DEPTH     = 128,
  parameter int AFULL_MARGIN  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  phv_deparser_if.slave       bus,
  output logic                o_phv_afull,
  output logic                o_pkt_afull,
  output logic                o_err,
  output logic                o_ovf,
  output logic [1:0]          o_dbg_state
);
  localparam int PW      = HEAD_WIDTH + TAG_WIDTH;
  localparam int PKT_NUM = HEAD_WIDTH / 128;
  localparam int CW      = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam int PHV_AW  = $clog2(PHV_DEPTH);
  localparam int PKT_AW  = $clog2(PKT_DEPTH);
  localparam logic [PHV_AW:0] PHV_FULL = (PHV_AW+1)'(PHV_DEPTH);
  localparam logic [PHV_AW:0] PHV_AF   = (PHV_AW+1)'(PHV_DEPTH - AFULL_MARGIN);
  localparam logic [PKT_AW:0] PKT_FULL = (PKT_AW+1)'(PKT_DEPTH);
  localparam logic [PKT_AW:0] PKT_AF   = (PKT_AW+1)'(PKT_DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FLUSH_PHV, S_FLUSH_PKT} state_t;

  // ---------------- slice FIFO ----------------
  logic [PW-1:0]     phv_mem [PHV_DEPTH];
  logic [PHV_AW-1:0] phv_wp, phv_rp;
  logic [PHV_AW:0]   phv_cnt;
  logic              phv_push, phv_pop, phv_have, phv_full;
  logic [PW-1:0]     phv_head;

  assign phv_have = (phv_cnt != '0);
  assign phv_full = (phv_cnt == PHV_FULL);
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign phv_push = bus.i_phv_valid && (!phv_full || phv_pop);
  assign phv_head = phv_mem[phv_rp];

  always_ff @(posedge i_clk) begin
    if (phv_push) phv_mem[phv_wp] <= bus.i_phv;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phv_wp  <= '0;
      phv_rp  <= '0;
      phv_cnt <= '0;
    end else begin
      if (phv_push) phv_wp <= phv_wp + 1'b1;
      if (phv_pop)  phv_rp <= phv_rp + 1'b1;
      if (phv_push && !phv_pop)      phv_cnt <= phv_cnt + 1'b1;
      else if (!phv_push && phv_pop) phv_cnt <= phv_cnt - 1'b1;
    end
  end

  // ---------------- beat FIFO ----------------
  logic [133:0]      pkt_mem [PKT_DEPTH];
  logic [PKT_AW-1:0] pkt_wp, pkt_rp;
  logic [PKT_AW:0]   pkt_cnt;
  logic              pkt_push, pkt_pop, pkt_have, pkt_full;
  logic [133:0]      pkt_head;

  assign pkt_have = (pkt_cnt != '0);
  assign pkt_full = (pkt_cnt == PKT_FULL);
  assign pkt_push = bus.i_pkt_valid && (!pkt_full || pkt_pop);
  assign pkt_head = pkt_mem[pkt_rp];

  always_ff @(posedge i_clk) begin
    if (pkt_push) pkt_mem[pkt_wp] <= bus.i_pkt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_wp  <= '0;
      pkt_rp  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (pkt_push) pkt_wp <= pkt_wp + 1'b1;
      if (pkt_pop)  pkt_rp <= pkt_rp + 1'b1;
      if (pkt_push && !pkt_pop)      pkt_cnt <= pkt_cnt + 1'b1;
      else if (!pkt_push && pkt_pop) pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  assign o_phv_afull = (phv_cnt >= PHV_AF);
  assign o_pkt_afull = (pkt_cnt >= PKT_AF);

  // ---------------- head decode ----------------
  logic [127:0]  chunks [PKT_NUM];
  logic [CW-1:0] chunk_sel;
  logic          chunk_last, beat_first, beat_last, slice_start, slice_tail, is_conf;
  logic          unused_tag;

  // Chunk 0 sits at the top of the slice data field.
  for (genvar k = 0; k < PKT_NUM; k++) begin : g_chunk
    assign chunks[k] = phv_head[HEAD_WIDTH-128*k-1 -: 128];
  end

  // The slice valid tag and spare tag bits ride along but do not steer the rebuild.
  assign unused_tag  = ^phv_head[HEAD_WIDTH +: TAG_WIDTH] ^ phv_head[HEAD_WIDTH+TAG_VALID_BIT];
  assign beat_first  = pkt_head[132];
  assign beat_last   = pkt_head[133];
  assign slice_start = phv_head[HEAD_WIDTH+TAG_START_BIT];
  assign slice_tail  = phv_head[HEAD_WIDTH+TAG_TAIL_BIT];

`ifdef DEPARSER_CONF_DROP_EN
  assign is_conf = (pkt_head[31:16] == 16'h9006);
`else
  assign is_conf = 1'b0;
`endif

  // ---------------- FSM ----------------
  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         conf_q, conf_d;
  logic         out_valid_d, err_d;
  logic [133:0] out_pkt_d;

  assign chunk_sel  = CW'(cnt_q % 8'(PKT_NUM));
  assign chunk_last = (chunk_sel == CW'(PKT_NUM - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      conf_q          <= 1'b0;
      bus.o_pkt_valid <= 1'b0;
      bus.o_pkt       <= '0;
      o_err           <= 1'b0;
      o_ovf           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      conf_q          <= conf_d;
      bus.o_pkt_valid <= out_valid_d;
      bus.o_pkt       <= out_pkt_d;
      o_err           <= err_d;
      if ((bus.i_phv_valid && !phv_push) || (bus.i_pkt_valid && !pkt_push)) o_ovf <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    conf_d      = conf_q;
    phv_pop     = 1'b0;
    pkt_pop     = 1'b0;
    out_valid_d = 1'b0;
    out_pkt_d   = '0;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_have && !beat_first) begin
          pkt_pop = 1'b1;
          err_d   = 1'b1;
        end
        if (phv_have && !slice_start) begin
          phv_pop = 1'b1;
          err_d   = 1'b1;
        end
        if (pkt_have && phv_have && beat_first && slice_start) begin
          state_d = S_EMIT;
          cnt_d   = '0;
          conf_d  = is_conf;
        end
      end
      S_EMIT: begin
        if (pkt_have && phv_have) begin
          out_valid_d = !conf_q;
          out_pkt_d   = {pkt_head[133:128], chunks[chunk_sel]};
          pkt_pop     = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          if (beat_last) begin
            if (slice_tail) begin
              phv_pop = 1'b1;
              state_d = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_FLUSH_PHV;
            end
          end else if (chunk_last) begin
            phv_pop = 1'b1;
            // Slices ran out before the beats did: pass the rest through untouched.
            if (slice_tail) begin
              err_d   = 1'b1;
              state_d = S_FLUSH_PKT;
            end
          end
        end
      end
      S_FLUSH_PHV: begin
        if (phv_have) begin
          phv_pop = 1'b1;
          if (slice_tail) state_d = S_IDLE;
        end
      end
      S_FLUSH_PKT: begin
        if (pkt_have) begin
          out_valid_d = !conf_q;
          out_pkt_d   = pkt_head;
          pkt_pop     = 1'b1;
          if (beat_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_dbg_state = state_q;
endmodule

// File: doc/phv_deparser.md
Name: phv_deparser

Overview:
- Return path of the parser pipeline: rebuilds the 134b packet stream from processed PHV slices.
- Buffers the original 134b beats in a beat FIFO and the PHV slices (HEAD_WIDTH+TAG_WIDTH) in a slice FIFO.
- Each output beat takes its control bits [133:128] from the buffered beat and its data [127:0] from the matching 128b chunk of the current slice.
- Sits between the last parser/action stage and the egress port.

Parameters:
HEAD_WIDTH, 1024, slice data width; PKT_NUM = HEAD_WIDTH/128 chunks per slice
TAG_WIDTH, 8, slice tag width, located at bits [HEAD_WIDTH+:TAG_WIDTH]
TAG_START_BIT, 0, tag bit: first slice of packet
TAG_TAIL_BIT, 1, tag bit: last slice of packet
TAG_VALID_BIT, 3, tag bit: slice valid
PHV_DEPTH, 16, slice FIFO entries (power of 2)
PKT_DEPTH, 128, beat FIFO entries (power of 2)
AFULL_MARGIN, 4, free entries at which the afull flags assert

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_phv_valid  in  1  slice write strobe
i_phv  in  HEAD_WIDTH+TAG_WIDTH  slice; chunk k = bits [HEAD_WIDTH-128*k-1 -: 128]
i_pkt_valid  in  1  original beat write strobe
i_pkt  in  134  original beat; [133:132] 01 first, 00 middle, 10 last, 11 single-beat
o_pkt_valid  out  1  output beat valid
o_pkt  out  134  rebuilt beat
o_phv_afull  out  1  slice FIFO free entries <= AFULL_MARGIN
o_pkt_afull  out  1  beat FIFO free entries <= AFULL_MARGIN
o_err  out  1  one-cycle pulse on each framing error
o_ovf  out  1  sticky: a write was dropped because its FIFO was full

Behaviour:
- Reset (i_rst sampled high at a clock edge): all outputs 0; FIFOs empty; FSM to IDLE; beat index 0.
  - Applies mid-packet; partially emitted packets are abandoned with no tail beat.
- Full FIFO write: write dropped, o_ovf set until reset. FIFO contents unchanged. No backpressure on the output.
- Beat index cnt (8b) counts beats of the current packet; chunk select = cnt mod PKT_NUM.
  - A slice is popped after chunk PKT_NUM-1 is used, or at packet end.
- FSM states: IDLE, EMIT, FLUSH_PHV, FLUSH_PKT.
- IDLE:
  - Both heads present, beat is 01 or 11, slice has the START tag bit -> EMIT, cnt=0.
  - Beat head present and not 01/11 -> pop it, pulse o_err, stay IDLE.
  - Slice head present without START -> pop it, pulse o_err, stay IDLE.
  - Both illegal heads in the same cycle -> pop both, single o_err pulse.
- EMIT, one beat per cycle while both heads present (stall with o_pkt_valid=0 otherwise):
  - o_pkt = {beat[133:128], chunk}.
  - Beat is 10/11 and slice has TAIL -> pop both, IDLE.
  - Beat is 10/11 and slice lacks TAIL -> pop beat, o_err, FLUSH_PHV.
  - Slice has TAIL, chunk PKT_NUM-1 used, beat not last -> pop both, o_err, FLUSH_PKT.
- FLUSH_PHV: pop slices until one with TAIL is popped (inclusive), then IDLE; no output.
- FLUSH_PKT: emit remaining beats unmodified (o_pkt = i_pkt copy) through the 10 beat, then IDLE.
- Latency: both FIFOs empty and in IDLE, start beat and start slice written in cycle N -> first o_pkt_valid in cycle N+3. Back-to-back beats thereafter.
- Simultaneous write and read on a full FIFO: the read frees the entry, so the write is accepted.

Optional Feature:
DEPARSER_CONF_DROP_EN:
- Defined: a packet whose first beat has [31:16]==16'h9006 (configuration packet) is consumed fully, from both FIFOs, with o_pkt_valid held 0. No o_err pulse unless framing is wrong.
- Not defined: such packets are rebuilt and emitted like any other.

Test Plan:
- 3-beat pkt (01,00,10), one slice tag START|TAIL|VALID with chunks 0..2 = A,B,C -> o_pkt data A,B,C with ctl 01,00,10; first beat at N+3, o_err=0.
- 10-beat pkt, 2 slices (START; TAIL) -> beats 0-7 take slice0 chunks 0-7, beats 8-9 take slice1 chunks 0-1.
- 2-beat pkt with 2 slices (second has TAIL) -> 2 beats out, o_err one pulse, second slice flushed; next packet rebuilt correctly.
- 12-beat pkt with a single START|TAIL slice -> beats 0-7 rebuilt, beats 8-11 passed unmodified, one o_err pulse.
- 20 slice writes with no reads, PHV_DEPTH=16 -> o_phv_afull high after 12, o_ovf=1 after write 17; reset clears o_ovf.
- With DEPARSER_CONF_DROP_EN, 2-beat pkt with [31:16]=0x9006, then a normal pkt -> no output for the first, second emitted intact.
